// File: rtl/rdid_sequencer.sv
// rdid_sequencer: turns a debounced button press or a start strobe into one
// get_rdid request. It then tracks the SPI master's chip_select with a timeout,
// captures the returned ID bytes, and reports sticky valid/match/timeout flags.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | waiting for a request (button edge or start)
// S_REQUEST    | one cycle; get_rdid high, flags cleared
// S_WAIT_LO    | waiting for chip_select to fall (timed)
// S_WAIT_HI    | transaction in flight, waiting for chip_select to rise (timed)
// S_CAPTURE    | one cycle; ID bytes latched and compared on exit
// S_TIMEOUT    | one cycle; timeout_err set on exit
module rdid_sequencer #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [15:0] TIMEOUT_CYCLES  = 16'd1000,
   parameter logic [7:0]  EXP_MAN_ID      = 8'h20,
   parameter logic [7:0]  EXP_MEM_TYPE    = 8'h20,
   parameter logic [7:0]  EXP_MEM_CAP     = 8'h15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn,
   input  logic        start,
   input  logic        chip_select,
   input  logic [7:0]  man_id,
   input  logic [7:0]  mem_type,
   input  logic [7:0]  mem_cap,
   output logic        get_rdid,
   output logic        busy,
   output logic        done,
   output logic        id_valid,
   output logic        id_match,
   output logic        timeout_err,
   output logic [23:0] id_bytes
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQUEST = 3'd1,
      S_WAIT_LO = 3'd2,
      S_WAIT_HI = 3'd3,
      S_CAPTURE = 3'd4,
      S_TIMEOUT = 3'd5
   } state_t;

   state_t      r_state;
   logic        r_sync1;
   logic        r_sync2;
   logic        r_db_lvl;
   logic        r_db_prev;
   logic [15:0] r_db_cnt;
   logic [15:0] r_to_cnt;

   logic        w_req;
   logic [15:0] w_to_next;
   logic        w_to_hit;
   logic        w_id_ok;

   // Synchronize the button and debounce it. The stability counter runs only
   // while the synchronized value disagrees with the accepted level; any
   // sample that agrees again (a bounce back) restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_db_lvl  <= 1'b0;
         r_db_prev <= 1'b0;
         r_db_cnt  <= 16'd0;
      end else begin
         r_sync1   <= btn;
         r_sync2   <= r_sync1;
         r_db_prev <= r_db_lvl;
         if (r_sync2 == r_db_lvl) begin
            r_db_cnt <= 16'd0;
         end else if (r_db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
            r_db_lvl <= r_sync2;
            r_db_cnt <= 16'd0;
         end else begin
            r_db_cnt <= r_db_cnt + 16'd1;
         end
      end
   end

   assign w_req     = (r_db_lvl & ~r_db_prev) | start;
   assign w_to_next = (r_to_cnt == 16'hFFFF) ? r_to_cnt : r_to_cnt + 16'd1;
   assign w_to_hit  = (w_to_next == TIMEOUT_CYCLES);
   assign w_id_ok   = (man_id == EXP_MAN_ID) && (mem_type == EXP_MEM_TYPE) &&
                      (mem_cap == EXP_MEM_CAP);

   // Request/response FSM with registered outputs and the wait-state timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_to_cnt    <= 16'd0;
         get_rdid    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         id_valid    <= 1'b0;
         id_match    <= 1'b0;
         timeout_err <= 1'b0;
         id_bytes    <= 24'h0;
      end else begin
         get_rdid <= 1'b0;
         done     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               busy <= 1'b0;
               if (w_req) begin
                  r_state     <= S_REQUEST;
                  get_rdid    <= 1'b1;
                  busy        <= 1'b1;
                  id_valid    <= 1'b0;
                  id_match    <= 1'b0;
                  timeout_err <= 1'b0;
                  r_to_cnt    <= 16'd0;
               end
            end
            S_REQUEST: begin
               r_state  <= S_WAIT_LO;
               r_to_cnt <= 16'd0;
            end
            S_WAIT_LO: begin
               if (!chip_select) begin
                  r_state  <= S_WAIT_HI;
                  r_to_cnt <= 16'd0;
               end else if (w_to_hit) begin
                  r_state <= S_TIMEOUT;
               end else begin
                  r_to_cnt <= w_to_next;
               end
            end
            S_WAIT_HI: begin
               if (chip_select) begin
                  r_state <= S_CAPTURE;
               end else if (w_to_hit) begin
                  r_state <= S_TIMEOUT;
               end else begin
                  r_to_cnt <= w_to_next;
               end
            end
            S_CAPTURE: begin
               r_state  <= S_IDLE;
               id_bytes <= {man_id, mem_type, mem_cap};
               id_valid <= 1'b1;
               id_match <= w_id_ok;
               done     <= 1'b1;
               busy     <= 1'b0;
            end
            S_TIMEOUT: begin
               r_state     <= S_IDLE;
               timeout_err <= 1'b1;
               busy        <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
